voltage_translator_sequencer: RTL and testbench
===============================================

VOLTAGE_TRANSLATOR_SEQUENCER -- requirements
Module: voltage_translator_sequencer

Interface
REQ-001 Parameter N_CH, default 4: number of independently enabled translator channels; legal range 1..32.
REQ-002 Parameter SETTLE_CYCLES, default 16: CLK cycles allowed for translator outputs to settle after any EN change; legal range 1..65535.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset; synchronous and active-high.
REQ-005 EN_REQ  input  N_CH  requested enable per channel, level-sensitive.
REQ-006 SRAM_RD_REQ  input  1  level request for an SRAM read window; translators must be off during the window.
REQ-007 SRAM_RD_DONE  input  1  single-cycle pulse ending the SRAM read window.
REQ-008 EN  output  N_CH  registered translator enables.
REQ-009 SRAM_RD_GNT  output  1  registered grant; high for the whole SRAM read window.
REQ-010 READY  output  1  registered; high when EN is stable and settled.
REQ-011 STATE  output  3  registered FSM state encoding for debug: OFF=0, SETTLE=1, ON=2, DRAIN=3, SRAM=4.

Function
REQ-012 The FSM SHALL have exactly five states: OFF, SETTLE, ON, DRAIN, SRAM.
REQ-013 The settle counter SHALL be wide enough to hold SETTLE_CYCLES-1. "Load" means set it to SETTLE_CYCLES-1. It decrements once per cycle in SETTLE and DRAIN only.
REQ-014 Priority in OFF/ON when SRAM_RD_REQ=1:
  - EN=0 (OFF): go to SRAM and assert SRAM_RD_GNT at the next edge.
  - EN!=0 (ON): EN<=0, load the counter, READY<=0, go to DRAIN.
REQ-015 In OFF/ON with SRAM_RD_REQ=0 and EN_REQ!=EN: EN<=EN_REQ, load the counter, READY<=0, go to SETTLE. EN therefore follows EN_REQ with 1-cycle latency.
REQ-016 In SETTLE:
  - SRAM_RD_REQ=1 takes precedence: EN<=0, load the counter, go to DRAIN.
  - Otherwise, EN_REQ!=EN: EN<=EN_REQ, reload the counter, stay in SETTLE.
  - Otherwise, at counter==0: READY<=1, go to ON if EN!=0, else OFF.
REQ-017 READY SHALL rise exactly SETTLE_CYCLES edges after the last EN update, provided no further change occurs.
REQ-018 In DRAIN: EN stays 0 and EN_REQ changes are ignored. At counter==0:
  - SRAM_RD_REQ=1: SRAM_RD_GNT<=1, go to SRAM.
  - SRAM_RD_REQ=0 (request withdrawn): load the counter, EN<=EN_REQ, go to SETTLE.
REQ-019 In SRAM: EN SHALL remain 0 regardless of EN_REQ. On SRAM_RD_DONE=1: SRAM_RD_GNT<=0, EN<=EN_REQ, load the counter, go to SETTLE. This holds even when EN_REQ=0, giving a settle before OFF.
REQ-020 SRAM_RD_DONE outside SRAM SHALL be ignored.
REQ-021 Safety invariant: SRAM_RD_GNT=1 and any EN bit =1 SHALL never occur in the same cycle.
REQ-022 Safety invariant: SRAM_RD_GNT SHALL rise only after EN has been all-zero for at least SETTLE_CYCLES consecutive cycles.
REQ-023 READY SHALL be 0 in DRAIN, SRAM and SETTLE, and 1 in OFF and ON.
REQ-024 With SETTLE_CYCLES=1, SETTLE and DRAIN SHALL each last exactly one cycle.

Reset
REQ-025 When RST=1 at an edge, outputs SHALL be EN=0, SRAM_RD_GNT=0, READY=0, STATE=SETTLE, counter loaded. This forces a full settle with translators off after every reset.
REQ-026 Reset SHALL take effect mid-operation in any state, including SRAM. GNT drops at that edge, and SRAM_RD_DONE is not required afterwards.
REQ-027 After RST deasserts with EN_REQ=0 and SRAM_RD_REQ=0: READY=1 and STATE=OFF exactly SETTLE_CYCLES edges later.

Verification (N_CH=4, SETTLE_CYCLES=4)
REQ-028 Reset release, EN_REQ=4'b0000:
  - 4 edges later STATE=OFF and READY=1.
  - EN=0 and GNT=0 throughout.
REQ-029 From OFF, EN_REQ=4'b0101:
  - Next edge EN=4'b0101, READY=0, STATE=SETTLE.
  - 4 edges later READY=1, STATE=ON.
REQ-030 In ON (EN=4'b1111), raise SRAM_RD_REQ:
  - Next edge EN=0, STATE=DRAIN.
  - 4 edges later GNT=1.
  - DONE pulse → GNT=0, EN=4'b1111, SETTLE; READY 4 edges later.
REQ-031 In SETTLE, change EN_REQ every 2 cycles 3 times, then hold:
  - EN tracks EN_REQ with 1-cycle latency.
  - READY rises only 4 edges after the final change.
REQ-032 Assert RST while in SRAM: GNT=0, EN=0, STATE=SETTLE at that edge. Checker asserts REQ-021/REQ-022 on every cycle of a randomised EN_REQ/SRAM_RD_REQ/DONE run of at least 10k cycles.

Source files
------------

// File: rtl/voltage_translator_sequencer.sv
// Sequencer for level-translator enables: settles EN after every change and
// hands exclusive bus access to SRAM reads only once the translators are off.
module voltage_translator_sequencer #(
  parameter int N_CH          = 4,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] EN_REQ,
  input  logic            SRAM_RD_REQ,
  input  logic            SRAM_RD_DONE,
  output logic [N_CH-1:0] EN,
  output logic            SRAM_RD_GNT,
  output logic            READY,
  output logic [2:0]      STATE
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_SETTLE = 3'd1,
    S_ON     = 3'd2,
    S_DRAIN  = 3'd3,
    S_SRAM   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [N_CH-1:0]   en_q, en_d;
  logic              gnt_q, gnt_d;
  logic              ready_q, ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_SETTLE;
      en_q    <= '0;
      gnt_q   <= 1'b0;
      ready_q <= 1'b0;
      cnt_q   <= CNT_LOAD;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      gnt_q   <= gnt_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    gnt_d   = gnt_q;
    ready_d = ready_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_OFF, S_ON: begin
        if (SRAM_RD_REQ) begin
          ready_d = 1'b0;
          if (en_q == '0) begin
            gnt_d   = 1'b1;
            state_d = S_SRAM;
          end else begin
            en_d    = '0;
            cnt_d   = CNT_LOAD;
            state_d = S_DRAIN;
          end
        end else if (EN_REQ != en_q) begin
          en_d    = EN_REQ;
          cnt_d   = CNT_LOAD;
          ready_d = 1'b0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // A pending SRAM request aborts the settle and forces translators off.
        if (SRAM_RD_REQ) begin
          en_d    = '0;
          cnt_d   = CNT_LOAD;
          state_d = S_DRAIN;
        end else if (EN_REQ != en_q) begin
          en_d  = EN_REQ;
          cnt_d = CNT_LOAD;
        end else if (cnt_q == '0) begin
          ready_d = 1'b1;
          state_d = (en_q != '0) ? S_ON : S_OFF;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          if (SRAM_RD_REQ) begin
            gnt_d   = 1'b1;
            state_d = S_SRAM;
          end else begin
            en_d    = EN_REQ;
            cnt_d   = CNT_LOAD;
            state_d = S_SETTLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SRAM: begin
        if (SRAM_RD_DONE) begin
          gnt_d   = 1'b0;
          en_d    = EN_REQ;
          cnt_d   = CNT_LOAD;
          state_d = S_SETTLE;
        end
      end
      default: begin
        en_d    = '0;
        gnt_d   = 1'b0;
        ready_d = 1'b0;
        cnt_d   = CNT_LOAD;
        state_d = S_SETTLE;
      end
    endcase
  end

  assign EN          = en_q;
  assign SRAM_RD_GNT = gnt_q;
  assign READY       = ready_q;
  assign STATE       = state_q;

endmodule

// File: tb/tb_voltage_translator_sequencer.sv
// Bench for voltage_translator_sequencer: directed scenarios with fixed
// expectations, then a long randomised run against a timing-based model.
module tb_voltage_translator_sequencer;

  localparam int N = 4;
  localparam int S = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic [N-1:0] EN_REQ;
  logic         SRAM_RD_REQ;
  logic         SRAM_RD_DONE;
  logic [N-1:0] EN;
  logic         SRAM_RD_GNT;
  logic         READY;
  logic [2:0]   STATE;

  int checks = 0;
  int errors = 0;

  voltage_translator_sequencer #(.N_CH(N), .SETTLE_CYCLES(S)) dut (
    .CLK(CLK), .RST(RST), .EN_REQ(EN_REQ), .SRAM_RD_REQ(SRAM_RD_REQ),
    .SRAM_RD_DONE(SRAM_RD_DONE), .EN(EN), .SRAM_RD_GNT(SRAM_RD_GNT),
    .READY(READY), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  // Reference model: mode uses the debug encoding; age counts edges since the
  // translators last changed (or since drain began).
  logic [2:0]   m_mode;
  logic [N-1:0] m_en;
  logic         m_gnt, m_ready;
  int           m_age;

  task automatic model_step();
    if (RST) begin
      m_mode = 3'd1; m_en = '0; m_gnt = 1'b0; m_ready = 1'b0; m_age = 0;
    end else begin
      case (m_mode)
        3'd0, 3'd2: begin
          if (SRAM_RD_REQ) begin
            m_ready = 1'b0;
            if (m_en == '0) begin m_mode = 3'd4; m_gnt = 1'b1; end
            else begin m_en = '0; m_age = 0; m_mode = 3'd3; end
          end else if (EN_REQ != m_en) begin
            m_en = EN_REQ; m_age = 0; m_ready = 1'b0; m_mode = 3'd1;
          end
        end
        3'd1: begin
          if (SRAM_RD_REQ) begin m_en = '0; m_age = 0; m_mode = 3'd3; end
          else if (EN_REQ != m_en) begin m_en = EN_REQ; m_age = 0; end
          else begin
            m_age++;
            if (m_age >= S) begin m_ready = 1'b1; m_mode = (m_en != '0) ? 3'd2 : 3'd0; end
          end
        end
        3'd3: begin
          m_age++;
          if (m_age >= S) begin
            if (SRAM_RD_REQ) begin m_gnt = 1'b1; m_mode = 3'd4; end
            else begin m_en = EN_REQ; m_age = 0; m_mode = 3'd1; end
          end
        end
        default: begin
          if (SRAM_RD_DONE) begin m_gnt = 1'b0; m_en = EN_REQ; m_age = 0; m_mode = 3'd1; end
        end
      endcase
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      model_step();
      #1;
    end
  endtask

  // Safety invariants, checked every cycle for the whole run.
  int   zrun = 0;
  logic gnt_prev = 1'b0;
  always @(negedge CLK) begin
    if (SRAM_RD_GNT === 1'b1) begin
      checks++;
      if (EN !== '0) begin errors++; $display("FAIL inv_gnt_with_en EN=%b GNT=%b required EN=0", EN, SRAM_RD_GNT); end
      if (gnt_prev !== 1'b1) begin
        checks++;
        if (zrun < S) begin errors++; $display("FAIL inv_gnt_settle zero_run=%0d required>=%0d", zrun, S); end
      end
    end
    zrun     = (EN === '0) ? zrun + 1 : 0;
    gnt_prev = SRAM_RD_GNT;
  end

  task automatic test_reset();
    RST = 1'b1; EN_REQ = '0; SRAM_RD_REQ = 1'b0; SRAM_RD_DONE = 1'b0;
    step(2);
    checks++; if (STATE !== 3'd1) begin errors++; $display("FAIL rst_state got %0d want 1", STATE); end
    checks++; if (EN !== 4'b0000 || SRAM_RD_GNT !== 1'b0 || READY !== 1'b0) begin errors++; $display("FAIL rst_outputs EN=%b GNT=%b READY=%b want 0/0/0", EN, SRAM_RD_GNT, READY); end
    RST = 1'b0;
    for (int i = 1; i <= S; i++) begin
      step();
      checks++; if (READY !== (i == S) || STATE !== ((i == S) ? 3'd0 : 3'd1)) begin errors++; $display("FAIL rst_release edge%0d READY=%b STATE=%0d want %b/%0d", i, READY, STATE, (i == S), (i == S) ? 0 : 1); end
      checks++; if (EN !== 4'b0000 || SRAM_RD_GNT !== 1'b0) begin errors++; $display("FAIL rst_release_off EN=%b GNT=%b want 0/0", EN, SRAM_RD_GNT); end
    end
  endtask

  task automatic test_settle_on();
    EN_REQ = 4'b0101;
    step();
    checks++; if (EN !== 4'b0101 || READY !== 1'b0 || STATE !== 3'd1) begin errors++; $display("FAIL settle_start EN=%b READY=%b STATE=%0d want 0101/0/1", EN, READY, STATE); end
    step(S - 1);
    checks++; if (READY !== 1'b0 || STATE !== 3'd1) begin errors++; $display("FAIL settle_early READY=%b STATE=%0d want 0/1", READY, STATE); end
    step();
    checks++; if (READY !== 1'b1 || STATE !== 3'd2 || EN !== 4'b0101) begin errors++; $display("FAIL settle_on READY=%b STATE=%0d EN=%b want 1/2/0101", READY, STATE, EN); end
  endtask

  task automatic test_sram_from_on();
    EN_REQ = 4'b1111;
    step(S + 1);
    checks++; if (STATE !== 3'd2 || EN !== 4'b1111 || READY !== 1'b1) begin errors++; $display("FAIL on_1111 STATE=%0d EN=%b READY=%b want 2/1111/1", STATE, EN, READY); end
    SRAM_RD_REQ = 1'b1;
    step();
    checks++; if (EN !== 4'b0000 || STATE !== 3'd3 || READY !== 1'b0) begin errors++; $display("FAIL drain_entry EN=%b STATE=%0d READY=%b want 0000/3/0", EN, STATE, READY); end
    step(S - 1);
    checks++; if (SRAM_RD_GNT !== 1'b0 || STATE !== 3'd3) begin errors++; $display("FAIL drain_early GNT=%b STATE=%0d want 0/3", SRAM_RD_GNT, STATE); end
    step();
    checks++; if (SRAM_RD_GNT !== 1'b1 || STATE !== 3'd4 || EN !== 4'b0000) begin errors++; $display("FAIL sram_grant GNT=%b STATE=%0d EN=%b want 1/4/0000", SRAM_RD_GNT, STATE, EN); end
    EN_REQ = 4'b1010;
    step(2);
    checks++; if (EN !== 4'b0000 || SRAM_RD_GNT !== 1'b1) begin errors++; $display("FAIL sram_hold EN=%b GNT=%b want 0000/1", EN, SRAM_RD_GNT); end
    EN_REQ = 4'b1111; SRAM_RD_REQ = 1'b0; SRAM_RD_DONE = 1'b1;
    step();
    SRAM_RD_DONE = 1'b0;
    checks++; if (SRAM_RD_GNT !== 1'b0 || EN !== 4'b1111 || STATE !== 3'd1) begin errors++; $display("FAIL sram_done GNT=%b EN=%b STATE=%0d want 0/1111/1", SRAM_RD_GNT, EN, STATE); end
    step(S);
    checks++; if (READY !== 1'b1 || STATE !== 3'd2) begin errors++; $display("FAIL sram_resettle READY=%b STATE=%0d want 1/2", READY, STATE); end
  endtask

  task automatic test_settle_tracking();
    logic [N-1:0] seq [3];
    seq[0] = 4'b0011; seq[1] = 4'b1000; seq[2] = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      EN_REQ = seq[k];
      step();
      checks++; if (EN !== seq[k] || READY !== 1'b0) begin errors++; $display("FAIL track_%0d EN=%b READY=%b want %b/0", k, EN, READY, seq[k]); end
      if (k < 2) step();
    end
    step(S - 1);
    checks++; if (READY !== 1'b0) begin errors++; $display("FAIL track_early READY=%b want 0", READY); end
    step();
    checks++; if (READY !== 1'b1 || STATE !== 3'd2 || EN !== 4'b0110) begin errors++; $display("FAIL track_final READY=%b STATE=%0d EN=%b want 1/2/0110", READY, STATE, EN); end
  endtask

  task automatic test_done_ignored();
    SRAM_RD_DONE = 1'b1;
    step();
    SRAM_RD_DONE = 1'b0;
    checks++; if (STATE !== 3'd2 || EN !== 4'b0110 || SRAM_RD_GNT !== 1'b0 || READY !== 1'b1) begin errors++; $display("FAIL done_ignored STATE=%0d EN=%b GNT=%b READY=%b want 2/0110/0/1", STATE, EN, SRAM_RD_GNT, READY); end
  endtask

  task automatic test_rst_in_sram();
    SRAM_RD_REQ = 1'b1;
    step(S + 1);
    checks++; if (STATE !== 3'd4 || SRAM_RD_GNT !== 1'b1) begin errors++; $display("FAIL rst_sram_pre STATE=%0d GNT=%b want 4/1", STATE, SRAM_RD_GNT); end
    step(2);
    RST = 1'b1;
    step();
    checks++; if (SRAM_RD_GNT !== 1'b0 || EN !== 4'b0000 || STATE !== 3'd1 || READY !== 1'b0) begin errors++; $display("FAIL rst_sram GNT=%b EN=%b STATE=%0d READY=%b want 0/0000/1/0", SRAM_RD_GNT, EN, STATE, READY); end
    RST = 1'b0; SRAM_RD_REQ = 1'b0; EN_REQ = '0;
    step(S);
    checks++; if (STATE !== 3'd0 || READY !== 1'b1) begin errors++; $display("FAIL rst_sram_recover STATE=%0d READY=%b want 0/1", STATE, READY); end
  endtask

  task automatic test_sram_from_off();
    SRAM_RD_REQ = 1'b1;
    step();
    checks++; if (STATE !== 3'd4 || SRAM_RD_GNT !== 1'b1 || READY !== 1'b0 || EN !== 4'b0000) begin errors++; $display("FAIL off_sram STATE=%0d GNT=%b READY=%b EN=%b want 4/1/0/0000", STATE, SRAM_RD_GNT, READY, EN); end
    SRAM_RD_REQ = 1'b0;
    step(2);
    checks++; if (STATE !== 3'd4 || SRAM_RD_GNT !== 1'b1) begin errors++; $display("FAIL off_sram_hold STATE=%0d GNT=%b want 4/1", STATE, SRAM_RD_GNT); end
    SRAM_RD_DONE = 1'b1;
    step();
    SRAM_RD_DONE = 1'b0;
    checks++; if (STATE !== 3'd1 || SRAM_RD_GNT !== 1'b0 || READY !== 1'b0) begin errors++; $display("FAIL off_sram_done STATE=%0d GNT=%b READY=%b want 1/0/0", STATE, SRAM_RD_GNT, READY); end
    step(S);
    checks++; if (STATE !== 3'd0 || READY !== 1'b1) begin errors++; $display("FAIL off_sram_settle STATE=%0d READY=%b want 0/1", STATE, READY); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 10000; c++) begin
      RST = ($urandom_range(0, 511) == 0);
      if ($urandom_range(0, 9) == 0) EN_REQ = N'($urandom);
      if ($urandom_range(0, 19) == 0) SRAM_RD_REQ = ~SRAM_RD_REQ;
      SRAM_RD_DONE = ($urandom_range(0, 5) == 0);
      step();
      checks++; if (EN !== m_en) begin errors++; $display("FAIL rand_en cyc%0d got %b want %b", c, EN, m_en); end
      checks++; if (SRAM_RD_GNT !== m_gnt) begin errors++; $display("FAIL rand_gnt cyc%0d got %b want %b", c, SRAM_RD_GNT, m_gnt); end
      checks++; if (READY !== m_ready) begin errors++; $display("FAIL rand_ready cyc%0d got %b want %b", c, READY, m_ready); end
      checks++; if (STATE !== m_mode) begin errors++; $display("FAIL rand_state cyc%0d got %0d want %0d", c, STATE, m_mode); end
    end
    RST = 1'b0; SRAM_RD_REQ = 1'b0; SRAM_RD_DONE = 1'b0;
  endtask

  initial begin
    m_mode = 3'd1; m_en = '0; m_gnt = 1'b0; m_ready = 1'b0; m_age = 0;
    test_reset();
    test_settle_on();
    test_sram_from_on();
    test_settle_tracking();
    test_done_ignored();
    test_rst_in_sram();
    test_sram_from_off();
    test_random();
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
